entropy_encode_ac_run_stream: RTL and testbench

- Parametrised, handshaked successor to the per-coefficient AC run encoder.
- Consumes one quantised AC coefficient per beat in slice scan order and counts zero runs.
- On each nonzero coefficient it emits the adaptive Rice/exp-Golomb run codeword, selected by the previous run, as a right-aligned value, length and mask.
- Sits between the AC scan/quantiser and the bit packer; trailing zeros at slice end are never coded.

---
 rtl/entropy_encode_ac_run_stream.sv | 198 +++++++++++++++++++
 tb/tb_entropy_encode_ac_run_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/entropy_encode_ac_run_stream.sv
// entropy_encode_ac_run_stream
// Counts zero runs over a slice-ordered stream of quantised AC coefficients and,
// on each nonzero coefficient, emits the adaptive Rice/exp-Golomb run codeword
// chosen by the previous run. The codeword is right-aligned; leading zeros are
// implied by cw_len.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   in_valid/in_ready             coefficient beat handshake
//   in_coeff                      coefficient (only zero/nonzero matters)
//   in_slice_first/in_slice_last  slice boundary markers for the beat
//   cw_valid/cw_ready             codeword handshake
//   cw_bits, cw_len, cw_mask      right-aligned codeword, its length, low-len mask
//   err_run_ovf                   sticky flag, a run counter saturated
module entropy_encode_ac_run_stream #(
    parameter int unsigned COEFF_WIDTH = 20,
    parameter int unsigned RUN_WIDTH   = 12,
    parameter int unsigned CW_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COEFF_WIDTH-1:0] in_coeff,
    input  logic                   in_slice_first,
    input  logic                   in_slice_last,
    output logic                   cw_valid,
    input  logic                   cw_ready,
    output logic [CW_WIDTH-1:0]    cw_bits,
    output logic [5:0]             cw_len,
    output logic [CW_WIDTH-1:0]    cw_mask,
    output logic                   err_run_ovf
);

    localparam int unsigned VW = RUN_WIDTH + 2;
    localparam int unsigned LW = 6;
    localparam logic [RUN_WIDTH-1:0] RUN_MAX   = '1;
    localparam logic [RUN_WIDTH-1:0] PREV_INIT = RUN_WIDTH'(4);

    logic [RUN_WIDTH-1:0] run_q, prev_run_q;
    logic                 ovf_q;

    logic                 s1_valid_q;
    logic                 s1_eg_q;
    logic [1:0]           s1_k_q;
    logic [VW-1:0]        s1_n_q;
    logic [1:0]           s1_esc_q;

    logic                 cw_valid_q;
    logic [CW_WIDTH-1:0]  cw_bits_q, cw_mask_q;
    logic [LW-1:0]        cw_len_q;

    // Handshake: stage 2 frees when empty or drained; stage 1 follows it.
    logic s2_load, s1_adv, accept, nz;
    assign s2_load  = !cw_valid_q || cw_ready;
    assign s1_adv   = s2_load || !s1_valid_q;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;
    assign nz       = |in_coeff;

    // A slice-first beat codes against the slice-start state.
    logic [RUN_WIDTH-1:0] r_eff, p_eff;
    logic [VW-1:0]        r_ext, p_ext;
    assign r_eff = in_slice_first ? '0 : run_q;
    assign p_eff = in_slice_first ? PREV_INIT : prev_run_q;
    assign r_ext = VW'(r_eff);
    assign p_ext = VW'(p_eff);

    // Code class selection from the previous run.
    logic          cls_eg_d;
    logic [1:0]    cls_k_d, cls_esc_d;
    logic [VW-1:0] cls_n_d;

    always_comb begin
        cls_eg_d  = 1'b1;
        cls_k_d   = 2'd0;
        cls_n_d   = r_ext;
        cls_esc_d = 2'd0;
        if (p_ext < VW'(2)) begin
            if (r_ext < VW'(3)) begin
                cls_eg_d = 1'b0;
            end else begin
                cls_k_d   = 2'd1;
                cls_n_d   = r_ext - VW'(3);
                cls_esc_d = 2'd3;
            end
        end else if (p_ext < VW'(4)) begin
            if (r_ext < VW'(2)) begin
                cls_eg_d = 1'b0;
            end else begin
                cls_k_d   = 2'd1;
                cls_n_d   = r_ext - VW'(2);
                cls_esc_d = 2'd2;
            end
        end else if (p_ext == VW'(4)) begin
            cls_k_d = 2'd0;
        end else if (p_ext < VW'(9)) begin
            if (r_ext < VW'(4)) begin
                cls_eg_d = 1'b0;
                cls_k_d  = 2'd1;
            end else begin
                cls_k_d   = 2'd2;
                cls_n_d   = r_ext - VW'(4);
                cls_esc_d = 2'd2;
            end
        end else if (p_ext < VW'(15)) begin
            cls_k_d = 2'd1;
        end else begin
            cls_k_d = 2'd2;
        end
    end

    // Codeword formation from the registered class.
    logic [VW-1:0]       v_c;
    logic [LW-1:0]       lg_c, q_c, cw_len_d;
    logic [CW_WIDTH-1:0] cw_bits_d, cw_mask_d;

    always_comb begin
        v_c  = s1_n_q + (VW'(1) << s1_k_q);
        lg_c = '0;
        for (int i = 0; i < int'(VW); i++) begin
            if (v_c[i]) lg_c = LW'(i);
        end
        if (s1_eg_q) begin
            q_c       = lg_c - LW'(s1_k_q);
            cw_bits_d = CW_WIDTH'(v_c);
            cw_len_d  = (q_c << 1) + LW'(s1_k_q) + LW'(1) + LW'(s1_esc_q);
        end else begin
            q_c       = LW'(s1_n_q >> s1_k_q);
            cw_bits_d = CW_WIDTH'((VW'(1) << s1_k_q) |
                                  (s1_n_q & ((VW'(1) << s1_k_q) - VW'(1))));
            cw_len_d  = q_c + LW'(1) + LW'(s1_k_q);
        end
        cw_mask_d = '0;
        for (int i = 0; i < int'(CW_WIDTH); i++) begin
            cw_mask_d[i] = (LW'(i) < cw_len_d);
        end
    end

    // Run state, stage 1 and stage 2 registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q      <= '0;
            prev_run_q <= PREV_INIT;
            ovf_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_eg_q    <= 1'b0;
            s1_k_q     <= '0;
            s1_n_q     <= '0;
            s1_esc_q   <= '0;
            cw_valid_q <= 1'b0;
            cw_bits_q  <= '0;
            cw_len_q   <= '0;
            cw_mask_q  <= '0;
        end else begin
            if (accept) begin
                if (nz) begin
                    run_q      <= '0;
                    prev_run_q <= r_eff;
                end else begin
                    prev_run_q <= p_eff;
                    if (in_slice_last) begin
                        run_q <= '0;
                    end else if (r_eff == RUN_MAX) begin
                        run_q <= RUN_MAX;
                        ovf_q <= 1'b1;
                    end else begin
                        run_q <= r_eff + RUN_WIDTH'(1);
                    end
                end
            end
            if (s1_adv) begin
                s1_valid_q <= accept && nz;
                if (accept && nz) begin
                    s1_eg_q  <= cls_eg_d;
                    s1_k_q   <= cls_k_d;
                    s1_n_q   <= cls_n_d;
                    s1_esc_q <= cls_esc_d;
                end
            end
            if (s2_load) begin
                cw_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    cw_bits_q <= cw_bits_d;
                    cw_len_q  <= cw_len_d;
                    cw_mask_q <= cw_mask_d;
                end
            end
        end
    end

    assign cw_valid    = cw_valid_q;
    assign cw_bits     = cw_bits_q;
    assign cw_len      = cw_len_q;
    assign cw_mask     = cw_mask_q;
    assign err_run_ovf = ovf_q;

endmodule

// File: tb/tb_entropy_encode_ac_run_stream.sv
// Bench for entropy_encode_ac_run_stream: directed and randomized beats checked
// against a queue-based reference model of the run coding rules.
module tb_entropy_encode_ac_run_stream;

    localparam int unsigned CWW = 8;
    localparam int unsigned RW  = 5;
    localparam int unsigned CW  = 16;
    localparam int          RMAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, in_slice_first, in_slice_last;
    logic [CWW-1:0] in_coeff;
    logic          cw_valid, cw_ready, err_run_ovf;
    logic [CW-1:0] cw_bits, cw_mask;
    logic [5:0]    cw_len;

    always #5 clk = ~clk;

    entropy_encode_ac_run_stream #(
        .COEFF_WIDTH(CWW), .RUN_WIDTH(RW), .CW_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
        .in_slice_first(in_slice_first), .in_slice_last(in_slice_last),
        .cw_valid(cw_valid), .cw_ready(cw_ready),
        .cw_bits(cw_bits), .cw_len(cw_len), .cw_mask(cw_mask),
        .err_run_ovf(err_run_ovf)
    );

    typedef struct {int bits; int len;} cw_t;
    cw_t exp_q[$];

    int checks = 0;
    int passes = 0;
    int m_run  = 0;
    int m_prev = 4;
    int m_ovf  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Codeword of run r given previous run p, straight from the coding rules.
    task automatic encode(input int r, input int p, output int bits, output int len);
        int k, n, esc, v, q;
        bit eg;
        eg = 1; k = 0; n = r; esc = 0;
        if (p <= 1)       begin if (r < 3) eg = 0; else begin k = 1; n = r - 3; esc = 3; end end
        else if (p <= 3)  begin if (r < 2) eg = 0; else begin k = 1; n = r - 2; esc = 2; end end
        else if (p == 4)  begin k = 0; end
        else if (p <= 8)  begin k = 1; if (r < 4) eg = 0; else begin k = 2; n = r - 4; esc = 2; end end
        else if (p <= 14) begin k = 1; end
        else              begin k = 2; end
        if (!eg) begin
            bits = (1 << k) | (r % (1 << k));
            len  = (r >> k) + 1 + k;
        end else begin
            v    = n + (1 << k);
            q    = ($clog2(v + 1) - 1) - k;
            bits = v;
            len  = 2 * q + k + 1 + esc;
        end
    endtask

    task automatic model_accept(input int coeff, input bit f, input bit l);
        int r, p;
        cw_t e;
        r = f ? 0 : m_run;
        p = f ? 4 : m_prev;
        if (coeff != 0) begin
            encode(r, p, e.bits, e.len);
            exp_q.push_back(e);
            m_prev = r;
            m_run  = 0;
        end else begin
            m_prev = p;
            if (l) m_run = 0;
            else if (r == RMAX) begin m_run = RMAX; m_ovf = 1; end
            else m_run = r + 1;
        end
    endtask

    task automatic step(input logic v, input logic [CWW-1:0] c, input logic f,
                        input logic l, input logic rdy, output bit acc);
        in_valid = v; in_coeff = c; in_slice_first = f; in_slice_last = l; cw_ready = rdy;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!(exp_q.size() >= 2 && !rdy)));
        chk("err_run_ovf", 32'(err_run_ovf), 32'(m_ovf));
        if (cw_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cw_valid", 32'(cw_valid), 32'(0));
            end else begin
                chk("cw_bits", 32'(cw_bits), 32'(exp_q[0].bits));
                chk("cw_len",  32'(cw_len),  32'(exp_q[0].len));
                chk("cw_mask", 32'(cw_mask), 32'((1 << exp_q[0].len) - 1));
                if (rdy) void'(exp_q.pop_front());
            end
        end
        acc = v && in_ready;
        if (acc) model_accept(int'(c), f, l);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [CWW-1:0] c, input logic f, input logic l, input logic rdy);
        bit acc;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, c, f, l, rdy, acc);
        if (!acc) chk("send_timeout", 32'(acc), 32'(1));
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) send('0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; cw_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_cw_valid", 32'(cw_valid), 32'(0));
        chk("rst_cw_bits",  32'(cw_bits),  32'(0));
        chk("rst_cw_len",   32'(cw_len),   32'(0));
        chk("rst_cw_mask",  32'(cw_mask),  32'(0));
        chk("rst_ovf",      32'(err_run_ovf), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        exp_q.delete();
        m_run = 0; m_prev = 4; m_ovf = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int nsent, cyc;
        logic [CWW-1:0] bp_c [$];
        reset_n = 1'b0; in_valid = 1'b0; in_coeff = '0;
        in_slice_first = 1'b0; in_slice_last = 1'b0; cw_ready = 1'b1;
        do_reset();

        // Basic adaptation.
        send(8'd5, 1'b1, 1'b0, 1'b1);
        zeros(2); send(8'd7, 1'b0, 1'b0, 1'b1);
        zeros(3); send(8'd9, 1'b0, 1'b0, 1'b1);
        drain();

        // prev_run in 5..8 and then 2..3.
        zeros(6); send(8'd1, 1'b0, 1'b0, 1'b1);
        zeros(3); send(8'd2, 1'b0, 1'b0, 1'b1);
        zeros(6); send(8'd3, 1'b0, 1'b0, 1'b1);
        drain();

        // prev_run >= 15.
        zeros(20); send(8'd4, 1'b0, 1'b0, 1'b1);
        send(8'd6, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: random beats with 10 nonzeros, cw_ready low for 5 cycles.
        for (int i = 0; i < 10; i++) begin
            for (int z = int'($urandom_range(0, 2)); z > 0; z--) bp_c.push_back('0);
            bp_c.push_back(CWW'($urandom_range(1, 255)));
        end
        nsent = 0; cyc = 0;
        while ((nsent < bp_c.size() || exp_q.size() > 0) && cyc < 200) begin
            if (nsent < bp_c.size()) step(1'b1, bp_c[nsent], 1'b0, 1'b0, cyc >= 5, acc);
            else step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
            if (acc) nsent++;
            cyc++;
        end
        chk("bp_all_sent", 32'(nsent), 32'(bp_c.size()));
        drain();

        // Slice boundaries.
        send(8'd3, 1'b1, 1'b0, 1'b1);
        zeros(3); send('0, 1'b0, 1'b1, 1'b1);
        drain();
        send(8'd8, 1'b1, 1'b0, 1'b1);
        send('0, 1'b1, 1'b1, 1'b1);
        drain();
        send(8'd5, 1'b0, 1'b0, 1'b1);
        drain();

        // Run saturation.
        zeros(40); send(8'd1, 1'b0, 1'b0, 1'b1);
        drain();
        chk("ovf_set", 32'(err_run_ovf), 32'(1));

        // Reset with a codeword pending.
        send(8'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        chk("pending_before_reset", 32'(cw_valid), 32'(exp_q.size() > 0));
        do_reset();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 9) < 6) ? CWW'(0) : CWW'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
